xor_gate: RTL and testbench



---
 rtl/xor_gate.sv | 51 +++++
 tb/tb_xor_gate.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/xor_gate.sv
// Bitwise XOR: combinational c (0 cycles) plus registered c_q/parity_q/zero_q/out_valid (1 cycle); no backpressure.
// Define XOR_GATE_STATS_EN to add the saturating 16-bit op_count port.
module xor_gate #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  input  logic             in_valid,
  output logic             out_valid,
  output logic [WIDTH-1:0] c_q,
  output logic             parity_q,
  output logic             zero_q
`ifdef XOR_GATE_STATS_EN
  ,
  output logic [15:0]      op_count
`endif
);

  assign c = a ^ b;

  // Result registers keep their last value when in_valid is low; only out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      c_q       <= '0;
      parity_q  <= 1'b0;
      zero_q    <= 1'b1;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        c_q      <= c;
        parity_q <= ^c;
        zero_q   <= (c == '0);
      end
    end
  end

`ifdef XOR_GATE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= 16'd0;
    end else if (in_valid && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xor_gate.sv
// Randomized scoreboard bench for xor_gate: WIDTH=4 for the registered path, WIDTH=1 for the truth table.
module tb_xor_gate;

  typedef struct {
    logic [3:0] c;
    logic       p;
    logic       z;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a, b, c, c_q;
  logic       in_valid, out_valid, parity_q, zero_q;
  logic       a1, b1, c1, in_valid1, out_valid1, c_q1, parity_q1, zero_q1;
`ifdef XOR_GATE_STATS_EN
  logic [15:0] op_count, op_count1;
`endif

  exp_t q[$];
  exp_t last_exp;
  int   accepts   = 0;
  int   n_checks  = 0;
  int   n_pass    = 0;

  always #5 clk = ~clk;

  xor_gate #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
    .in_valid(in_valid), .out_valid(out_valid), .c_q(c_q),
    .parity_q(parity_q), .zero_q(zero_q)
`ifdef XOR_GATE_STATS_EN
    , .op_count(op_count)
`endif
  );

  xor_gate #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1),
    .in_valid(in_valid1), .out_valid(out_valid1), .c_q(c_q1),
    .parity_q(parity_q1), .zero_q(zero_q1)
`ifdef XOR_GATE_STATS_EN
    , .op_count(op_count1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: a result bit is set exactly where the operand bits differ.
  function automatic logic [3:0] ref_xor(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (x[i] != y[i]);
    return r;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.c = 4'd0;
    e.p = 1'b0;
    e.z = 1'b1;
    return e;
  endfunction

  task automatic issue(input logic [3:0] ta, input logic [3:0] tb, input logic v);
    exp_t e;
    @(negedge clk);
    a = ta;
    b = tb;
    in_valid = v;
    e.c = ref_xor(ta, tb);
    e.p = 1'($countones(e.c) % 2);
    e.z = (e.c == 4'd0);
    if (v && rst_n) begin
      q.push_back(e);
      accepts++;
    end
    #1 chk("c_comb", 32'(c), 32'(e.c));
  endtask

  // Monitor: one cycle after each capture the DUT must present the queued result.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      last_exp = e;
      chk("out_valid_hi", 32'(out_valid), 32'd1);
    end else begin
      chk("out_valid_lo", 32'(out_valid), 32'd0);
    end
    chk("c_q", 32'(c_q), 32'(last_exp.c));
    chk("parity_q", 32'(parity_q), 32'(last_exp.p));
    chk("zero_q", 32'(zero_q), 32'(last_exp.z));
`ifdef XOR_GATE_STATS_EN
    chk("op_count", 32'(op_count), (accepts > 65535) ? 32'hFFFF : 32'(accepts));
`endif
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] seq_a [5] = '{4'h3, 4'hC, 4'h7, 4'h0, 4'h9};
    logic [3:0] seq_b [5] = '{4'h5, 4'hC, 4'h8, 4'hE, 4'h1};
    logic [1:0] tt;
    last_exp = reset_exp();
    rst_n = 1'b1; in_valid = 1'b0; a = 4'd0; b = 4'd0;
    a1 = 1'b0; b1 = 1'b0; in_valid1 = 1'b0;
    #1 rst_n = 1'b0;

    // Truth table on the 1-bit instance while held in reset.
    for (int i = 0; i < 4; i++) begin
      #9;
      tt = 2'(i);
      a1 = tt[1];
      b1 = tt[0];
      #1 chk("tt_c", 32'(c1), 32'(a1 != b1));
    end
    chk("rst_c_q", 32'(c_q), 32'd0);
    chk("rst_zero_q", 32'(zero_q), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);

    @(negedge clk) rst_n = 1'b1;

    issue(4'b1010, 4'b0110, 1'b1);
    issue(4'b0000, 4'b0001, 1'b0);
    issue(4'hF, 4'hF, 1'b1);
    issue(4'h1, 4'h0, 1'b1);

    // Asynchronous reset between edges while a result is on the outputs.
    @(posedge clk);
    #2 chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    q.delete();
    last_exp = reset_exp();
    accepts = 0;
    #1;
    chk("arst_c_q", 32'(c_q), 32'd0);
    chk("arst_zero_q", 32'(zero_q), 32'd1);
    chk("arst_parity_q", 32'(parity_q), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
`ifdef XOR_GATE_STATS_EN
    chk("arst_op_count", 32'(op_count), 32'd0);
`endif
    a = 4'h9; b = 4'h3;
    #1 chk("arst_c_tracks", 32'(c), 32'hA);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 5; i++) issue(seq_a[i], seq_b[i], 1'b1);
    issue(4'h0, 4'h0, 1'b0);
`ifdef XOR_GATE_STATS_EN
    chk("op_count_5", 32'(op_count), 32'd5);
`endif

    for (int i = 0; i < 200; i++)
      issue(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));

`ifdef XOR_GATE_STATS_EN
    for (int i = 0; i < 65540; i++) issue(4'(i), 4'(i >> 4), 1'b1);
    issue(4'h0, 4'h0, 1'b0);
    chk("op_count_sat", 32'(op_count), 32'hFFFF);
`endif

    issue(4'h0, 4'h0, 1'b0);
    @(posedge clk);
    #3 chk("drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
